// File: rtl/ctrl_regfile.sv
// ctrl_regfile: shadowed control register file on the GS bus.
// Writes land in a shadow bank and are copied to the live bank atomically
// by a COMMIT through control register 0; DISCARD reverts the shadow bank.
// Optional feature macro: CTRL_REGFILE_READBACK_EN enables bus readback.
// With the macro undefined, rd_valid/rd_data are tied low and reads have
// no effect at all, not even on err_cnt.
module ctrl_regfile #(
   parameter int unsigned NUM_REGS  = 16,
   parameter int unsigned DATA_W    = 16,
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                           bus_clk,
   input  logic                           nrst,
   input  logic                           bus_valid,
   input  logic                           bus_wr,
   input  logic [63:0]                    bus_addr,
   input  logic [31:0]                    bus_data,
   output logic [(NUM_REGS-1)*DATA_W-1:0] regs_live,
   output logic [NUM_REGS-2:0]            reg_upd,
   output logic                           rd_valid,
   output logic [31:0]                    rd_data,
   output logic                           pending,
   output logic [15:0]                    err_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam logic [DATA_W-1:0] RST_V = RESET_VAL[DATA_W-1:0];
`ifdef CTRL_REGFILE_READBACK_EN
   localparam bit READS_COUNT = 1'b1;
`else
   localparam bit READS_COUNT = 1'b0;
`endif

   // Input stage
   logic        r_valid;
   logic        r_wr;
   logic [63:0] r_addr;
   logic [31:0] r_data;

   // Register banks and status
   logic [NUM_REGS-1:1][DATA_W-1:0] r_shadow;
   logic [NUM_REGS-1:1][DATA_W-1:0] r_live;
   logic [NUM_REGS-2:0]             r_upd;
   logic                            r_pending;
   logic [15:0]                     r_err;

   // Decode and next-state wires
   logic [63:0]                     w_off;
   logic                            w_in_range;
   logic [IDX_W-1:0]                w_idx;
   logic                            w_wr_en;
   logic                            w_commit;
   logic                            w_discard;
   logic                            w_shadow_wr;
   logic                            w_acc_err;
   logic [NUM_REGS-2:0]             w_diff;
   logic [NUM_REGS-1:1][DATA_W-1:0] w_shadow_n;
   logic [NUM_REGS-1:1][DATA_W-1:0] w_live_n;
   logic [NUM_REGS-2:0]             w_upd_n;
   logic                            w_pending_n;
   logic [15:0]                     w_err_n;
   logic                            w_unused_ok;

   // Register the raw bus every cycle; only this copy is decoded
   always_ff @(posedge bus_clk or negedge nrst) begin
      if (!nrst) begin
         r_valid <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= 64'h0;
         r_data  <= 32'h0;
      end else begin
         r_valid <= bus_valid;
         r_wr    <= bus_wr;
         r_addr  <= bus_addr;
         r_data  <= bus_data;
      end
   end

   // Full 64-bit range check, no wrap-around below BASE_ADDR
   assign w_off       = r_addr - BASE_ADDR;
   assign w_in_range  = (r_addr >= BASE_ADDR) && (w_off < 64'(NUM_REGS));
   assign w_idx       = w_off[IDX_W-1:0];
   assign w_wr_en     = r_valid & r_wr & w_in_range;
   assign w_commit    = w_wr_en && (w_idx == '0) && r_data[0];
   assign w_discard   = w_wr_en && (w_idx == '0) && r_data[1] && !r_data[0];
   assign w_shadow_wr = w_wr_en && (w_idx != '0);
   assign w_acc_err   = r_valid & ~w_in_range & (r_wr | READS_COUNT);
   assign w_unused_ok = ^r_data;

   // Per-register change flags used to build reg_upd on commit
   for (genvar k = 1; k < NUM_REGS; k++) begin : g_diff
      assign w_diff[k-1] = (r_live[k] != r_shadow[k]);
   end

   // Next-state of banks, pending flag, update pulses and error counter
   always_comb begin
      w_shadow_n  = r_shadow;
      w_live_n    = r_live;
      w_upd_n     = '0;
      w_pending_n = r_pending;
      w_err_n     = r_err;
      if (w_commit) begin
         w_live_n    = r_shadow;
         w_upd_n     = w_diff;
         w_pending_n = 1'b0;
      end else if (w_discard) begin
         w_shadow_n  = r_live;
         w_pending_n = 1'b0;
      end
      if (w_shadow_wr) begin
         w_shadow_n[w_idx] = r_data[DATA_W-1:0];
         w_pending_n       = 1'b1;
      end
      if (w_acc_err && (r_err != 16'hFFFF)) begin
         w_err_n = r_err + 16'd1;
      end
   end

   // Apply stage
   always_ff @(posedge bus_clk or negedge nrst) begin
      if (!nrst) begin
         r_shadow  <= {(NUM_REGS-1){RST_V}};
         r_live    <= {(NUM_REGS-1){RST_V}};
         r_upd     <= '0;
         r_pending <= 1'b0;
         r_err     <= 16'h0;
      end else begin
         r_shadow  <= w_shadow_n;
         r_live    <= w_live_n;
         r_upd     <= w_upd_n;
         r_pending <= w_pending_n;
         r_err     <= w_err_n;
      end
   end

   assign regs_live = r_live;
   assign reg_upd   = r_upd;
   assign pending   = r_pending;
   assign err_cnt   = r_err;

`ifdef CTRL_REGFILE_READBACK_EN
   logic        r_rd_valid;
   logic [31:0] r_rd_data;
   logic [31:0] w_rd_data_n;

   // Read response mux: control word, live register or error pattern
   always_comb begin
      w_rd_data_n = 32'h0;
      if (!w_in_range) begin
         w_rd_data_n = 32'hDEAD_BEEF;
      end else if (w_idx == '0) begin
         w_rd_data_n = {16'h0, 8'(NUM_REGS), 7'h0, r_pending};
      end else begin
         w_rd_data_n = 32'(r_live[w_idx]);
      end
   end

   // Read response register, zero when no response is due
   always_ff @(posedge bus_clk or negedge nrst) begin
      if (!nrst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= 32'h0;
      end else if (r_valid && !r_wr) begin
         r_rd_valid <= 1'b1;
         r_rd_data  <= w_rd_data_n;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= 32'h0;
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
`else
   assign rd_valid = 1'b0;
   assign rd_data  = 32'h0;
`endif

endmodule
